// File: rtl/matrix_stream_ctrl.sv
// Sequencer for the 2x2 matrix multiplier: loads A and B from a word stream, runs the core, streams C back.
// Optional RUN watchdog enabled by defining MSC_TIMEOUT_EN.
module matrix_stream_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic                mm_enable,
  output logic [4*DATA_W-1:0] mm_A,
  output logic [4*DATA_W-1:0] mm_B,
  input  logic [4*DATA_W-1:0] mm_C,
  input  logic                mm_done,
  output logic                busy,
  output logic                error
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                r_state;
  logic [1:0]            r_cnt;
  logic [4*DATA_W-1:0]   r_mm_A;
  logic [4*DATA_W-1:0]   r_mm_B;
  logic [4*DATA_W-1:0]   r_C;
  logic                  r_enable;

  logic                  w_s_ready;
  logic                  w_m_valid;
  logic                  w_s_fire;
  logic                  w_m_fire;
  logic                  w_last_word;

`ifdef MSC_TIMEOUT_EN
  logic [4:0]            r_tcnt;
  logic                  r_error;
`endif

  assign w_s_ready   = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_m_valid   = (r_state == DRAIN);
  assign w_s_fire    = s_valid && w_s_ready;
  assign w_m_fire    = w_m_valid && m_ready;
  assign w_last_word = (r_cnt == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= LOAD_A;
      r_cnt    <= 2'd0;
      r_mm_A   <= '0;
      r_mm_B   <= '0;
      r_C      <= '0;
      r_enable <= 1'b0;
`ifdef MSC_TIMEOUT_EN
      r_tcnt   <= 5'd0;
      r_error  <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_s_fire) begin
            r_mm_A[r_cnt*DATA_W +: DATA_W] <= s_data;
            r_cnt <= r_cnt + 2'd1;
            if (w_last_word) r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_s_fire) begin
            r_mm_B[r_cnt*DATA_W +: DATA_W] <= s_data;
            r_cnt <= r_cnt + 2'd1;
            if (w_last_word) begin
              r_state  <= RUN;
              r_enable <= 1'b1;
`ifdef MSC_TIMEOUT_EN
              r_tcnt   <= 5'd0;
`endif
            end
          end
        end
        // Operands stay frozen here; only the first done pulse is honoured.
        RUN: begin
          if (mm_done) begin
            r_C      <= mm_C;
            r_enable <= 1'b0;
            r_state  <= DRAIN;
`ifdef MSC_TIMEOUT_EN
          end else if (r_tcnt == 5'(TIMEOUT - 1)) begin
            r_error  <= 1'b1;
            r_enable <= 1'b0;
            r_state  <= LOAD_A;
          end else begin
            r_tcnt <= r_tcnt + 5'd1;
`endif
          end
        end
        DRAIN: begin
          if (w_m_fire) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last_word) r_state <= LOAD_A;
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  // Result word is selected by the word counter, so it holds while stalled.
  assign s_ready   = w_s_ready;
  assign m_valid   = w_m_valid;
  assign m_data    = r_C[r_cnt*DATA_W +: DATA_W];
  assign m_last    = w_m_valid && w_last_word;
  assign mm_enable = r_enable;
  assign mm_A      = r_mm_A;
  assign mm_B      = r_mm_B;
  assign busy      = (r_state != LOAD_A) || (r_cnt != 2'd0);

`ifdef MSC_TIMEOUT_EN
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule
